mem_bus: RTL

MEM_BUS -- requirements
Module: mem_bus

---
 rtl/mem_bus.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus.sv
// mem_bus: CPU memory map with a mirrored RAM, a loader write port and an I/O
// page holding an output port, a 4-deep TX FIFO and a reloading interval timer.
module mem_bus #(
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [15:0]       address,
  input  logic [7:0]        wr_data,
  input  logic              wr_enable,
  output logic [7:0]        rd_data,
  input  logic              ld_en,
  input  logic [RAM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [7:0]        port_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              irq
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [3:0] {
    REG_PORT_OUT = 4'h0,
    REG_TX_DATA  = 4'h1,
    REG_STATUS   = 4'h2,
    REG_RELOAD   = 4'h3,
    REG_COUNT    = 4'h4,
    REG_CTRL     = 4'h5
  } io_reg_e;

  logic [7:0]        ram_q [RAM_DEPTH];
  logic              ram_sel;
  logic              io_sel;
  logic              io_wr;
  io_reg_e           io_reg;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [7:0]        ram_wdata;

  logic [7:0]        rd_data_q, rd_data_d;
  logic [7:0]        port_out_q, port_out_d;
  logic [3:0][7:0]   fifo_q, fifo_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              expired_q, expired_d;
  logic [7:0]        reload_q, reload_d;
  logic [7:0]        timer_q, timer_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              irq_q, irq_d;

  logic              pop;
  logic              push_req;
  logic              push_ok;
  logic              fire;

  // The 0xF page mirrors page 0 so the CPU vectors at the top land in RAM.
  assign ram_sel = (address[15:12] == 4'h0) || (address[15:12] == 4'hF);
  assign io_sel  = (address[15:4] == 12'h800);
  assign io_wr   = wr_enable && io_sel;
  assign io_reg  = io_reg_e'(address[3:0]);

  assign pop      = (count_q != 3'd0) && tx_ready;
  assign push_req = io_wr && (io_reg == REG_TX_DATA);
  assign push_ok  = push_req && ((count_q < 3'd4) || pop);
  assign fire     = ctrl_q[0] && (timer_q == 8'd0);

  // The loader owns the RAM write port whenever it is active, even in reset.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = address[RAM_AW-1:0];
    ram_wdata = wr_data;
    if (ld_en) begin
      ram_we    = 1'b1;
      ram_waddr = ld_addr;
      ram_wdata = ld_data;
    end else if (wr_enable && ram_sel && resetn) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  always_comb begin
    rd_data_d = 8'hFF;
    if (ram_sel) begin
      rd_data_d = ram_q[address[RAM_AW-1:0]];
    end else if (io_sel) begin
      case (io_reg)
        REG_PORT_OUT: rd_data_d = port_out_q;
        REG_STATUS:   rd_data_d = {4'b0000, overflow_q, expired_q,
                                   (count_q == 3'd0), (count_q == 3'd4)};
        REG_RELOAD:   rd_data_d = reload_q;
        REG_COUNT:    rd_data_d = timer_q;
        REG_CTRL:     rd_data_d = {6'b000000, ctrl_q};
        default:      rd_data_d = 8'h00;
      endcase
    end
  end

  // A push into a full FIFO alongside a pop reuses the slot being vacated.
  always_comb begin
    port_out_d = port_out_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    expired_d  = expired_q;
    reload_d   = reload_q;
    timer_d    = timer_q;
    ctrl_d     = ctrl_q;

    if (push_ok) begin
      fifo_d[wr_ptr_q] = wr_data;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (io_wr) begin
      case (io_reg)
        REG_PORT_OUT: port_out_d = wr_data;
        REG_STATUS: begin
          if (wr_data[2]) expired_d  = 1'b0;
          if (wr_data[3]) overflow_d = 1'b0;
        end
        REG_RELOAD:   reload_d = wr_data;
        REG_CTRL:     ctrl_d   = wr_data[1:0];
        default:      ;
      endcase
    end

    if (io_wr && (io_reg == REG_RELOAD)) begin
      timer_d = wr_data;
    end else if (ctrl_q[0]) begin
      timer_d = fire ? reload_q : timer_q - 8'd1;
    end

    // Setting events win over a same-cycle write-one-to-clear.
    if (push_req && !push_ok) overflow_d = 1'b1;
    if (fire)                 expired_d  = 1'b1;

    irq_d = expired_d & ctrl_d[1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_q  <= 8'h00;
      port_out_q <= 8'h00;
      fifo_q     <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      expired_q  <= 1'b0;
      reload_q   <= 8'h00;
      timer_q    <= 8'h00;
      ctrl_q     <= 2'b00;
      irq_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      port_out_q <= port_out_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      expired_q  <= expired_d;
      reload_q   <= reload_d;
      timer_q    <= timer_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign port_out = port_out_q;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign tx_valid = (count_q != 3'd0);
  assign irq      = irq_q;

endmodule
